// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and MMIO offsets for the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] c_off_led = 32'h0000_0000;
    localparam logic [31:0] c_off_sw  = 32'h0000_0004;
    localparam logic [31:0] c_off_cnt = 32'h0000_0008;

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Load/store request and response channels with modports.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;

    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface
`default_nettype wire

// File: rtl/dmem_responder_ram_sp.sv
`default_nettype none
// ============================================================================
// Module      : ram_sp
// Description : Single-port synchronous word RAM, registered read data.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_sp #(
    parameter int DEPTH_W = 7
) (
    input  wire logic               clk,
    input  wire logic               en,
    input  wire logic               we,
    input  wire logic [DEPTH_W-1:0] addr,
    input  wire logic [31:0]        wdata,
    output logic      [31:0]        rdata
);

    logic [31:0] r_mem [2**DEPTH_W];

    // rdata only moves on an enabled access, so it holds through a stalled response
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= wdata;
            end
            rdata <= r_mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Timed load/store responder with word RAM and LED/SW/counter MMIO.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_W      = 9,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_0400
) (
    input  wire logic       clk,
    input  wire logic       reset,
    dmem_responder_if.slave bus,
    input  wire logic [7:0] sw,
    output logic      [7:0] led
);

    localparam logic [3:0]  c_wait    = 4'(WAIT_STATES);
    localparam logic [31:0] c_ram_lim = 32'h1 << ADDR_W;
    localparam logic [31:0] c_led_a   = MMIO_BASE + c_off_led;
    localparam logic [31:0] c_sw_a    = MMIO_BASE + c_off_sw;
    localparam logic [31:0] c_cnt_a   = MMIO_BASE + c_off_cnt;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_wcnt;
    logic        r_we;
    logic [31:0] r_addr, r_wdata;
    logic [31:0] r_cnt;
    logic [7:0]  r_led;
    logic        r_src_ram, r_rsp_err;
    logic [31:0] r_rsp_data;

    logic        w_accept, w_access;
    logic        w_acc_we;
    logic [31:0] w_acc_addr, w_acc_wdata, w_word;
    logic        w_hit_ram, w_hit_led, w_hit_sw, w_hit_cnt, w_unmapped;
    logic [31:0] w_mmio_rdata, w_ram_rdata;

    assign w_accept = (r_state == IDLE) && bus.req_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_access    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (c_wait == 4'd0) begin
                        w_access    = 1'b1;
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_wcnt == 4'd0) begin
                    w_access    = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wcnt  <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                if (c_wait != 4'd0) begin
                    r_wcnt <= c_wait - 4'd1;
                end
            end else if (r_state == WAIT && r_wcnt != 4'd0) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
        end
    end

    // With zero wait states the access happens on the accept edge, straight from the bus
    assign w_acc_we    = (r_state == IDLE) ? bus.req_we    : r_we;
    assign w_acc_addr  = (r_state == IDLE) ? bus.req_addr  : r_addr;
    assign w_acc_wdata = (r_state == IDLE) ? bus.req_wdata : r_wdata;

    assign w_word     = w_acc_addr & ~32'h3;
    assign w_hit_ram  = w_acc_addr < c_ram_lim;
    assign w_hit_led  = !w_hit_ram && (w_word == c_led_a);
    assign w_hit_sw   = !w_hit_ram && (w_word == c_sw_a);
    assign w_hit_cnt  = !w_hit_ram && (w_word == c_cnt_a);
    assign w_unmapped = !(w_hit_ram || w_hit_led || w_hit_sw || w_hit_cnt);

    always_comb begin
        w_mmio_rdata = '0;
        if (w_hit_led) begin
            w_mmio_rdata = {24'd0, r_led};
        end else if (w_hit_sw) begin
            w_mmio_rdata = {24'd0, sw};
        end else if (w_hit_cnt) begin
            w_mmio_rdata = r_cnt;
        end
    end

    ram_sp #(
        .DEPTH_W (ADDR_W - 2)
    ) u_ram (
        .clk   (clk),
        .en    (w_access && w_hit_ram),
        .we    (w_acc_we),
        .addr  (w_acc_addr[ADDR_W-1:2]),
        .wdata (w_acc_wdata),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led <= 8'd0;
            r_cnt <= 32'd0;
        end else begin
            if (w_access && w_acc_we && w_hit_led) begin
                r_led <= w_acc_wdata[7:0];
            end
            if (w_access && w_acc_we && w_hit_cnt) begin
                r_cnt <= 32'd0;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_src_ram  <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else if (w_access) begin
            r_src_ram  <= w_hit_ram && !w_acc_we;
            r_rsp_data <= w_acc_we ? 32'd0 : w_mmio_rdata;
            r_rsp_err  <= w_unmapped;
        end
    end

    assign bus.req_ready = (r_state == IDLE);
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_rdata = r_src_ram ? w_ram_rdata : r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign led           = r_led;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed checks of dmem_responder at 1, 0 and 3 wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  sw;
    logic [2:0]  t_valid, t_we, t_rready;
    logic [31:0] t_addr  [3];
    logic [31:0] t_wdata [3];
    wire  [2:0]  o_rdy, o_rvalid, o_err;
    wire  [31:0] o_rdata [3];
    wire  [7:0]  led     [3];

    int unsigned cyc     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: one wait state, instance 1: none, instance 2: three
    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            dmem_responder_if bus ();
            assign bus.req_valid = t_valid[g];
            assign bus.req_we    = t_we[g];
            assign bus.req_addr  = t_addr[g];
            assign bus.req_wdata = t_wdata[g];
            assign bus.rsp_ready = t_rready[g];
            assign o_rdy[g]      = bus.req_ready;
            assign o_rvalid[g]   = bus.rsp_valid;
            assign o_rdata[g]    = bus.rsp_rdata;
            assign o_err[g]      = bus.rsp_err;

            dmem_responder #(
                .ADDR_W      (9),
                .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
                .MMIO_BASE   (32'h0000_0400)
            ) u_dut (
                .clk   (clk),
                .reset (reset),
                .bus   (bus),
                .sw    (sw),
                .led   (led[g])
            );
        end
    endgenerate

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic xact(input int k, input logic we, input logic [31:0] a, input logic [31:0] d,
                        input int hold, output logic [31:0] rd, output logic er,
                        output int lat, output int acc);
        logic busy_rdy, unstable;
        busy_rdy    = 1'b0;
        unstable    = 1'b0;
        t_rready[k] = 1'b0;
        t_valid[k]  = 1'b1;
        t_we[k]     = we;
        t_addr[k]   = a;
        t_wdata[k]  = d;
        @(posedge clk); #1;
        t_valid[k] = 1'b0;
        acc = int'(cyc);
        lat = 1;
        while (!o_rvalid[k] && lat < 40) begin
            if (o_rdy[k]) busy_rdy = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check_eq("rsp_arrives", 32'(o_rvalid[k]), 32'd1);
        if (o_rdy[k]) busy_rdy = 1'b1;
        rd = o_rdata[k];
        er = o_err[k];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!o_rvalid[k] || o_rdata[k] !== rd || o_err[k] !== er || o_rdy[k]) unstable = 1'b1;
        end
        t_rready[k] = 1'b1;
        @(posedge clk); #1;
        t_rready[k] = 1'b0;
        check_eq("req_ready_low_busy", 32'(busy_rdy), 32'd0);
        check_eq("back_to_idle", 32'(o_rdy[k]), 32'd1);
        if (hold > 0) check_eq("stall_stable", 32'(unstable), 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, acc, a1, a2;

    initial begin
        t_valid  = '0;
        t_we     = '0;
        t_rready = '0;
        sw       = 8'd0;
        for (int i = 0; i < 3; i++) begin
            t_addr[i]  = '0;
            t_wdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 32'(o_rdy[0]), 32'd1);
        check_eq("rst_rsp_valid", 32'(o_rvalid[0]), 32'd0);
        check_eq("rst_rsp_rdata", o_rdata[0], 32'd0);
        check_eq("rst_rsp_err", 32'(o_err[0]), 32'd0);
        check_eq("rst_led", 32'(led[0]), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // W=1 RAM store/load
        xact(0, 1'b1, 32'h010, 32'hDEAD_BEEF, 0, rd, er, lat, acc);
        check_eq("w1_store_lat", 32'(lat), 32'd2);
        check_eq("w1_store_rdata", rd, 32'd0);
        check_eq("w1_store_err", 32'(er), 32'd0);
        xact(0, 1'b0, 32'h010, 32'h0, 0, rd, er, lat, acc);
        check_eq("w1_load_lat", 32'(lat), 32'd2);
        check_eq("w1_load_rdata", rd, 32'hDEAD_BEEF);
        check_eq("w1_load_err", 32'(er), 32'd0);
        xact(0, 1'b1, 32'h1FF, 32'h0BAD_F00D, 0, rd, er, lat, acc);
        xact(0, 1'b0, 32'h1FC, 32'h0, 0, rd, er, lat, acc);
        check_eq("ram_last_word", rd, 32'h0BAD_F00D);

        // W=0 and W=3 latency
        xact(1, 1'b1, 32'h014, 32'h1357_9BDF, 0, rd, er, lat, acc);
        check_eq("w0_store_lat", 32'(lat), 32'd1);
        xact(1, 1'b0, 32'h014, 32'h0, 0, rd, er, lat, acc);
        check_eq("w0_load_lat", 32'(lat), 32'd1);
        check_eq("w0_load_rdata", rd, 32'h1357_9BDF);
        xact(2, 1'b1, 32'h018, 32'h1234_5678, 0, rd, er, lat, acc);
        check_eq("w3_store_lat", 32'(lat), 32'd4);
        xact(2, 1'b0, 32'h018, 32'h0, 0, rd, er, lat, acc);
        check_eq("w3_load_lat", 32'(lat), 32'd4);
        check_eq("w3_load_rdata", rd, 32'h1234_5678);

        // MMIO LED and switches
        xact(0, 1'b1, 32'h400, 32'hFFFF_FFA5, 0, rd, er, lat, acc);
        check_eq("led_after_store", 32'(led[0]), 32'h0000_00A5);
        xact(0, 1'b0, 32'h400, 32'h0, 0, rd, er, lat, acc);
        check_eq("led_readback", rd, 32'h0000_00A5);
        sw = 8'h3C;
        xact(0, 1'b0, 32'h404, 32'h0, 0, rd, er, lat, acc);
        check_eq("sw_read", rd, 32'h0000_003C);
        check_eq("sw_read_err", 32'(er), 32'd0);
        xact(0, 1'b1, 32'h404, 32'hFFFF_FFFF, 0, rd, er, lat, acc);
        xact(0, 1'b0, 32'h404, 32'h0, 0, rd, er, lat, acc);
        check_eq("sw_write_ignored", rd, 32'h0000_003C);

        // Cycle counter: value read is cycles from clear edge to the edge before the load access
        xact(0, 1'b1, 32'h408, 32'hFFFF_FFFF, 0, rd, er, lat, a1);
        xact(0, 1'b0, 32'h010, 32'h0, 0, rd, er, lat, acc);
        xact(0, 1'b0, 32'h408, 32'h0, 0, rd, er, lat, a2);
        check_eq("cnt_since_clear", rd, 32'(a2 - a1 - 1));

        // Unmapped accesses
        xact(0, 1'b1, 32'h000, 32'hCAFE_F00D, 0, rd, er, lat, acc);
        xact(0, 1'b0, 32'h800, 32'h0, 0, rd, er, lat, acc);
        check_eq("unmapped_load_rdata", rd, 32'd0);
        check_eq("unmapped_load_err", 32'(er), 32'd1);
        xact(0, 1'b1, 32'h800, 32'h1111_1111, 0, rd, er, lat, acc);
        check_eq("unmapped_store_err", 32'(er), 32'd1);
        xact(0, 1'b0, 32'h000, 32'h0, 0, rd, er, lat, acc);
        check_eq("unmapped_store_ram", rd, 32'hCAFE_F00D);
        check_eq("unmapped_store_led", 32'(led[0]), 32'h0000_00A5);
        xact(0, 1'b0, 32'h40C, 32'h0, 0, rd, er, lat, acc);
        check_eq("past_cnt_err", 32'(er), 32'd1);

        // Back-pressure
        xact(0, 1'b0, 32'h010, 32'h0, 5, rd, er, lat, acc);
        check_eq("stall_rdata", rd, 32'hDEAD_BEEF);

        // Reset during WAIT of a store on the W=3 instance
        xact(2, 1'b1, 32'h400, 32'h0000_005A, 0, rd, er, lat, acc);
        check_eq("w3_led", 32'(led[2]), 32'h0000_005A);
        t_valid[2] = 1'b1;
        t_we[2]    = 1'b1;
        t_addr[2]  = 32'h018;
        t_wdata[2] = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        t_valid[2] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_eq("midrst_rsp_valid", 32'(o_rvalid[2]), 32'd0);
        check_eq("midrst_req_ready", 32'(o_rdy[2]), 32'd1);
        check_eq("midrst_led", 32'(led[2]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        t_rready[2] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("midrst_no_rsp", 32'(o_rvalid[2]), 32'd0);
        t_rready[2] = 1'b0;
        xact(2, 1'b0, 32'h018, 32'h0, 0, rd, er, lat, acc);
        check_eq("midrst_ram_kept", rd, 32'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
